// File: rtl/key_pio_debounced_pkg.sv
// Shared definitions for the debounced key PIO: register map, edge/irq mode codes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package key_pio_pkg;

    // Register word addresses; 5..7 are unmapped and read as zero.
    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_RAW    = 3'd1,
        ADDR_MASK   = 3'd2,
        ADDR_EDGE   = 3'd3,
        ADDR_STATUS = 3'd4
    } reg_addr_e;

    // Which debounced transition sets an edge-capture bit.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Interrupt source: debounced level or captured edges, both gated by the mask.
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Picks the edge pulse matching the configured polarity.
    function automatic logic edge_select(input int edge_type, input logic rise, input logic fall);
        logic sel;
        sel = rise | fall;
        if (edge_type == EDGE_RISE) begin
            sel = rise;
        end else if (edge_type == EDGE_FALL) begin
            sel = fall;
        end
        return sel;
    endfunction

endpackage

// File: rtl/key_pio_debounced_if.sv
// Avalon-MM slave bus plus key pins and irq for the debounced key PIO.
// Latency: n/a (wiring only).
// Backpressure: none; the slave never stalls the bus.
interface key_pio_debounced_if #(
    parameter int WIDTH = 4
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    // Bus master / board side drives requests and pins.
    modport master (
        output address, chipselect, write_n, writedata, in_port,
        input  readdata, irq
    );

    // The PIO itself.
    modport slave (
        input  address, chipselect, write_n, writedata, in_port,
        output readdata, irq
    );
endinterface

// File: rtl/key_pio_debounced_channel.sv
// One key channel: 2-flop synchroniser, debounce counter, 1-cycle edge pulse.
// Latency: pin to edge pulse = 2 sync + DEBOUNCE_CYCLES clocks (edge_o is combinational from registers).
// Backpressure: none; the channel free-runs every clock.
module key_debounce_channel
    import key_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int EDGE_TYPE       = EDGE_FALL
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic raw_o,
    output logic stable_o,
    output logic pending_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic stable_q;
    logic prev_q;

    // Two-flop synchroniser for the asynchronous pin; idles at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the accepted state is just the synchroniser output, one clock later.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stable_q <= IDLE_LEVEL;
                end else begin
                    stable_q <= sync2_q;
                end
            end
            assign pending_o = 1'b0;
        end else begin : g_count
            localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_d;

            // Count consecutive disagreeing samples; the Nth one flips the state.
            // Any agreeing sample restarts the count, so the counter tops out at N-1.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync2_q == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Debounce state register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q    <= '0;
                    stable_q <= IDLE_LEVEL;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign pending_o = |cnt_q;
        end
    endgenerate

    // Delayed copy of the accepted state for edge detection; resets equal so release is edge-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= IDLE_LEVEL;
        end else begin
            prev_q <= stable_q;
        end
    end

    assign raw_o    = sync2_q;
    assign stable_o = stable_q;
    assign edge_o   = edge_select(EDGE_TYPE, stable_q & ~prev_q, ~stable_q & prev_q);

endmodule

// File: rtl/key_pio_debounced.sv
// Debounced key/switch PIO on Avalon-MM: data, raw, mask, W1C edge capture, status, one irq.
// Latency: readdata 1 clock after address; pin change to capture bit = DEBOUNCE_CYCLES+3 clocks.
// Backpressure: none; reads and writes complete in a single cycle with no wait states.
module key_pio_debounced
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter int IRQ_TYPE        = IRQ_EDGE
) (
    input logic                 clk,
    input logic                 reset,
    key_pio_debounced_if.slave  bus
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] edges;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr_en;

    // Only the low WIDTH bits of writedata are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL),
            .EDGE_TYPE       (EDGE_TYPE)
        ) u_ch (
            .clk       (clk),
            .rst       (reset),
            .pin_i     (bus.in_port[i]),
            .raw_o     (raw[i]),
            .stable_o  (stable[i]),
            .pending_o (pending[i]),
            .edge_o    (edges[i])
        );
    end

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Mask write and W1C capture update; a new edge is ORed in last so it beats a same-cycle clear.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && (bus.address == ADDR_MASK)) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            cap_d = cap_q & ~bus.writedata[WIDTH-1:0];
        end
        cap_d = cap_d | edges;
    end

    // Read mux, zero-extended to the bus width; sampled every clock regardless of chipselect.
    always_comb begin
        rdata_d = '0;
        case (bus.address)
            ADDR_DATA:   rdata_d[WIDTH-1:0] = stable;
            ADDR_RAW:    rdata_d[WIDTH-1:0] = raw;
            ADDR_MASK:   rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE:   rdata_d[WIDTH-1:0] = cap_q;
            ADDR_STATUS: rdata_d[WIDTH-1:0] = pending;
            default:     rdata_d = '0;
        endcase
    end

    // Register file state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = (IRQ_TYPE == IRQ_LEVEL) ? |(stable & mask_q) : |(cap_q & mask_q);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Bench for key_pio_debounced: register table, timed corner sequences, then random run vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_pio_debounced;

    localparam int W = 4;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    key_pio_debounced_if #(.WIDTH(W)) bus ();

    key_pio_debounced #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N),
        .IDLE_LEVEL      (1'b1),
        .EDGE_TYPE       (1),
        .IRQ_TYPE        (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [14];

    // Reference model state (values after the most recent clock edge).
    logic [W-1:0] m_pin_d1, m_pin_d2;   // pin as seen one and two clocks ago
    logic [W-1:0] m_hist [N];           // last N raw samples, [0] newest
    logic [W-1:0] m_data, m_prev, m_cap, m_mask, m_pend;
    logic [31:0]  m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        tick();
        check(name, bus.readdata, exp);
    endtask

    task automatic model_reset();
        m_pin_d1 = '1;
        m_pin_d2 = '1;
        for (int k = 0; k < N; k++) m_hist[k] = '1;
        m_data = '1;
        m_prev = '1;
        m_cap  = '0;
        m_mask = '0;
        m_pend = '0;
        m_rd   = '0;
    endtask

    // One clock edge of the reference: a change is accepted once the last N raw samples all
    // disagree with the accepted value; capture sets on a falling accepted value.
    task automatic model_step(input logic [2:0] a, input logic we, input logic [31:0] wd,
                              input logic [W-1:0] pin);
        logic [W-1:0] falls, nxt;
        logic         all_diff;
        case (a)
            3'd0:    m_rd = {28'd0, m_data};
            3'd1:    m_rd = {28'd0, m_pin_d2};
            3'd2:    m_rd = {28'd0, m_mask};
            3'd3:    m_rd = {28'd0, m_cap};
            3'd4:    m_rd = {28'd0, m_pend};
            default: m_rd = 32'd0;
        endcase
        falls = m_prev & ~m_data;
        m_cap = (m_cap & ~((we && a == 3'd3) ? wd[W-1:0] : '0)) | falls;
        if (we && a == 3'd2) m_mask = wd[W-1:0];
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_pin_d2;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < N; k++) if (m_hist[k][b] == m_data[b]) all_diff = 1'b0;
            nxt[b] = all_diff ? ~m_data[b] : m_data[b];
        end
        m_pend   = m_pin_d2 ^ nxt;
        m_prev   = m_data;
        m_data   = nxt;
        m_pin_d2 = m_pin_d1;
        m_pin_d1 = pin;
    endtask

    initial begin
        logic [W-1:0] pin;
        logic [2:0]   ra;
        logic         rwe;
        logic [31:0]  rwd;
        int           flip_div;

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.in_port    = 4'hF;

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        tick();
        check("reset readdata", bus.readdata, 32'h0);
        check("reset irq", {31'd0, bus.irq}, 32'h0);
        reset = 1'b0;

        // ---------------- register table ----------------
        tbl[0]  = '{3'd0, 1'b0, 32'h0,        32'hF, 1'b0};
        tbl[1]  = '{3'd1, 1'b0, 32'h0,        32'hF, 1'b0};
        tbl[2]  = '{3'd2, 1'b1, 32'hFFFF_FFF5, 32'h0, 1'b0};
        tbl[3]  = '{3'd5, 1'b1, 32'h0000_000F, 32'h0, 1'b0};
        tbl[4]  = '{3'd2, 1'b0, 32'h0,        32'h5, 1'b0};
        tbl[5]  = '{3'd3, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[6]  = '{3'd4, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[7]  = '{3'd6, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[8]  = '{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
        tbl[9]  = '{3'd2, 1'b0, 32'h0,        32'h5, 1'b0};
        tbl[10] = '{3'd2, 1'b1, 32'h0,        32'h5, 1'b0};
        tbl[11] = '{3'd2, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[12] = '{3'd3, 1'b1, 32'h0000_000F, 32'h0, 1'b0};
        tbl[13] = '{3'd3, 1'b0, 32'h0,        32'h0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            bus.address    = tbl[i].addr;
            bus.writedata  = tbl[i].wd;
            bus.chipselect = tbl[i].wr;
            bus.write_n    = ~tbl[i].wr;
            tick();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            check($sformatf("tbl[%0d] readdata", i), bus.readdata, tbl[i].exp_rd);
            check($sformatf("tbl[%0d] irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].exp_irq});
        end

        // ---------------- clean press on bit 2 ----------------
        wr(3'd2, 32'h4);
        bus.address = 3'd4;
        bus.in_port = 4'hB;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) check("press status early", bus.readdata, 32'h0);
            if (k == 5) check("press status pending", bus.readdata, 32'h4);
            if (k == 6) check("press irq at 6", {31'd0, bus.irq}, 32'h0);
            if (k == 7) check("press irq at 7", {31'd0, bus.irq}, 32'h1);
            if (k == 7) check("press status done", bus.readdata, 32'h0);
        end
        chk_rd("press capture", 3'd3, 32'h4);
        chk_rd("press data", 3'd0, 32'hB);

        // ---------------- bounce on bit 0 ----------------
        wr(3'd2, 32'h1);
        check("bounce irq masked", {31'd0, bus.irq}, 32'h0);
        bus.in_port = 4'hA;
        tick(); tick();
        bus.in_port = 4'hB;
        tick(); tick();
        bus.in_port = 4'hA;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("bounce irq k=%0d", k), {31'd0, bus.irq}, (k == 7) ? 32'h1 : 32'h0);
        end
        chk_rd("bounce capture", 3'd3, 32'h5);
        chk_rd("bounce data", 3'd0, 32'hA);

        // ---------------- write-1-to-clear ----------------
        wr(3'd2, 32'h4);
        check("w1c irq before", {31'd0, bus.irq}, 32'h1);
        wr(3'd3, 32'h1);
        check("w1c irq kept", {31'd0, bus.irq}, 32'h1);
        chk_rd("w1c partial", 3'd3, 32'h4);
        wr(3'd3, 32'h4);
        check("w1c irq dropped", {31'd0, bus.irq}, 32'h0);
        chk_rd("w1c all", 3'd3, 32'h0);
        for (int k = 0; k < 10; k++) tick();
        chk_rd("capture once", 3'd3, 32'h0);

        // ---------------- edge and clear on bit 1 in the same cycle ----------------
        bus.in_port = 4'h8;
        for (int k = 1; k <= 6; k++) tick();
        bus.address    = 3'd3;
        bus.writedata  = 32'h2;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk_rd("edge beats w1c", 3'd3, 32'h2);
        wr(3'd3, 32'h2);
        chk_rd("later w1c clears", 3'd3, 32'h0);

        // ---------------- reset during debounce on bit 3 ----------------
        bus.in_port = 4'hF;
        for (int k = 0; k < 10; k++) tick();
        chk_rd("rise not captured", 3'd3, 32'h0);
        chk_rd("released data", 3'd0, 32'hF);
        bus.in_port = 4'h7;
        bus.address = 3'd4;
        for (int k = 1; k <= 4; k++) tick();
        check("pending before reset", bus.readdata, 32'h8);
        reset = 1'b1;
        #1;
        check("irq in reset", {31'd0, bus.irq}, 32'h0);
        check("readdata in reset", bus.readdata, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        chk_rd("data after reset", 3'd0, 32'hF);
        chk_rd("status after reset", 3'd4, 32'h0);
        wr(3'd2, 32'h8);
        tick();
        tick();
        tick();
        check("fresh debounce irq early", {31'd0, bus.irq}, 32'h0);
        tick();
        check("fresh debounce irq", {31'd0, bus.irq}, 32'h1);
        chk_rd("fresh capture", 3'd3, 32'h8);

        // ---------------- random run against the reference model ----------------
        bus.in_port = 4'hF;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        pin = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            check($sformatf("rand readdata c=%0d", c), bus.readdata, m_rd);
            check($sformatf("rand irq c=%0d", c), {31'd0, bus.irq}, {31'd0, |(m_cap & m_mask)});
            flip_div = (c < 1500) ? 4 : 12;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, flip_div - 1) == 0) pin[b] = ~pin[b];
            end
            ra  = 3'($urandom_range(0, 7));
            rwe = ($urandom_range(0, 3) == 0);
            rwd = $urandom;
            bus.in_port    = pin;
            bus.address    = ra;
            bus.writedata  = rwd;
            bus.chipselect = rwe | ($urandom_range(0, 1) == 0);
            bus.write_n    = ~rwe;
            model_step(ra, rwe, rwd, pin);
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_pio_debounced.md
Name: key_pio_debounced

Overview:
- Parametrised successor to the single-bit key PIO: a WIDTH-bit input port for push-buttons and switches on the Avalon-MM system bus.
- Adds the following:
  - two-flop synchroniser per bit;
  - per-bit debounce counter;
  - selectable edge polarity;
  - per-bit write-1-to-clear edge capture;
  - level or edge interrupt mode.
- Sits between board keys and the CPU interconnect. It drives one irq line to the processor.

Parameters:
- WIDTH, 4: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required before a change is accepted. 0 = debounce bypassed.
- IDLE_LEVEL, 1: released-state level of every input. Keys are active-low, hence 1.
- EDGE_TYPE, 1: edge that sets capture. 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 1: 0 = level (irq from debounced data & mask), 1 = edge (irq from edge_capture & mask).

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-high.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  interrupt request to CPU.

Behaviour:
- Register map; all registers are WIDTH bits, zero-extended to 32 on read:
  - 0 DATA (RO): debounced state.
  - 1 RAW (RO): synchroniser output.
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAPTURE (RW1C).
  - 4 STATUS (RO): bit n = channel n debounce counter nonzero, i.e. a change is pending.
  - 5..7 read 0; writes to them are ignored.
- Read latency: readdata is updated every clk from the address; the value is valid 1 cycle after address is presented. chipselect is not required for reads.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0.
- Reset values:
  - sync stages, debounced state and previous debounced state = {WIDTH{IDLE_LEVEL}};
  - counters, IRQ_MASK, EDGE_CAPTURE, readdata = 0;
  - irq = 0.
- Synchroniser: 2 flops per bit. RAW = second stage.
- Debounce, per bit:
  - If RAW == stable: counter clears to 0.
  - Else: counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 while RAW != stable: stable <= RAW and counter <= 0. A change is accepted after exactly DEBOUNCE_CYCLES cycles of disagreement.
  - Any glitch back to the stable value restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES+1) and it never wraps.
  - DEBOUNCE_CYCLES=0: stable = RAW registered, with 1 cycle latency and no counter.
- Edge detect:
  - Compares stable against a 1-cycle delayed copy.
  - rise = stable & ~prev; fall = ~stable & prev; any = rise | fall, selected by EDGE_TYPE.
  - Edge pulse is 1 cycle wide.
- Edge capture, per bit:
  - Edge sets the bit.
  - Write to address 3 clears each bit where writedata bit = 1; bits written 0 are unchanged.
  - If an edge and a W1C on the same bit land in the same cycle, the edge wins: the bit stays 1.
- irq is combinational from registers:
  - IRQ_TYPE=0: |(DATA & IRQ_MASK).
  - IRQ_TYPE=1: |(EDGE_CAPTURE & IRQ_MASK).
  - Masking a pending bit drops irq in the same cycle the mask register updates.
- Total latency, pin change to capture bit set (DEBOUNCE_CYCLES=N>0): 2 sync + N + 1 edge-register = N+3 clk edges.
- Reset mid-debounce: all state returns to idle immediately. No edge is generated on reset release while inputs sit at IDLE_LEVEL.
- IRQ_MASK writes store only writedata[WIDTH-1:0].

Decomposition:
- Shared package key_pio_pkg holds:
  - register address constants (ADDR_DATA=0, ADDR_RAW=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_STATUS=4);
  - EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY);
  - IRQ_TYPE encodings (IRQ_LEVEL, IRQ_EDGE).
- One sub-module, key_debounce_channel:
  - single-bit synchroniser, debounce counter and edge pulse;
  - parameters DEBOUNCE_CYCLES, IDLE_LEVEL, EDGE_TYPE;
  - instantiated WIDTH times in a generate loop.
- Top level keeps the register file, capture, mask and irq logic.

Test Plan:
- All cases use WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1, EDGE_TYPE=1, IRQ_TYPE=1.
- Reset then idle: in_port=4'hF -> read addr0 = 0xF, addr3 = 0x0, irq=0; no capture after reset deasserts.
- Clean press: in_port[2] 1->0 and held -> STATUS[2]=1 during the count; EDGE_CAPTURE=0x4 exactly 7 clks after the pin change; with IRQ_MASK=0x4, irq=1 in the same cycle.
- Bounce: in_port[0] toggles 0,1,0 with 2-clk spacing, then holds 0 -> no capture until 4 consecutive stable cycles after the final transition; capture=0x1 once.
- W1C: capture=0x5, write 0x1 to addr3 -> read 0x4; irq stays 1 if mask=0x4. Write 0x4 -> 0x0, irq=0.
- Simultaneous W1C and new edge on bit 1 in the same cycle -> bit 1 reads 1 afterwards.
- Mid-debounce reset: assert reset during count on bit 3 -> DATA=0xF, STATUS=0; after release with in_port[3]=0 held, the capture fires only after a full fresh debounce.
